// File: rtl/daq_trigger_manager.sv
// ---------------------------------------------------------------------------
// daq_trigger_manager
//
// Qualifies and sequences board trigger sources into single start pulses for
// the DRS readout block. Each raw trigger is synchronised and edge detected,
// then masked. The software force trigger is added to the result. Qualified
// triggers pass through a 1-of-(prescale+1) prescaler. An accepted event
// issues one start pulse, waits for the readout busy cycle and then applies a
// holdoff before re-arming. Qualified triggers that arrive during dead time
// are counted as lost.
//
// Ports:
//   clock, reset_n         system clock, asynchronous active-low reset
//   trigger_i              raw asynchronous triggers (active high)
//   source_mask_i          per-source enable (1 = enabled)
//   force_trigger_i        synchronous software trigger, level sampled
//   enable_i               arm enable
//   clear_i                synchronous clear of timestamp/counters/prescaler
//   prescale_i             accept 1 of every prescale_i+1 qualified triggers
//   holdoff_i              dead cycles after busy_i falls
//   busy_i                 readout busy from the DRS block
//   trigger_o              one-cycle start pulse
//   armed_o                high while ARMED
//   state_o                FSM state (IDLE=0 ARMED=1 FIRE=2 WAIT_BUSY=3 HOLDOFF=4)
//   timestamp_o            free-running cycle counter
//   event_count_o          accepted events (wraps)
//   event_timestamp_o      timestamp captured at the last accept
//   event_source_o         qualified vector at the last accept, MSB = force
//   lost_count_o           qualified triggers during dead time (saturates)
//
// Handshake: busy_i is a plain level from the readout block. After each start
// pulse the block waits for busy_i to go high and then low. If busy_i never
// rises within BUSY_TIMEOUT cycles, the wait ends as if busy had fallen.
// ---------------------------------------------------------------------------
module daq_trigger_manager #(
  parameter int TS_WIDTH       = 48,
  parameter int EVT_WIDTH      = 32,
  parameter int N_SOURCES      = 4,
  parameter int PRESCALE_WIDTH = 16,
  parameter int HOLDOFF_WIDTH  = 16,
  parameter int BUSY_TIMEOUT   = 15
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [N_SOURCES-1:0]      trigger_i,
  input  logic [N_SOURCES-1:0]      source_mask_i,
  input  logic                      force_trigger_i,
  input  logic                      enable_i,
  input  logic                      clear_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  input  logic [HOLDOFF_WIDTH-1:0]  holdoff_i,
  input  logic                      busy_i,
  output logic                      trigger_o,
  output logic                      armed_o,
  output logic [2:0]                state_o,
  output logic [TS_WIDTH-1:0]       timestamp_o,
  output logic [EVT_WIDTH-1:0]      event_count_o,
  output logic [TS_WIDTH-1:0]       event_timestamp_o,
  output logic [N_SOURCES:0]        event_source_o,
  output logic [EVT_WIDTH-1:0]      lost_count_o
);

  localparam int BTO_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [BTO_W-1:0] BTO_LAST = BTO_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARMED     = 3'd1,
    S_FIRE      = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_HOLDOFF   = 3'd4
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [N_SOURCES-1:0]      r_sync1, r_sync2, r_hist;
  logic                      r_trigger, r_armed;
  logic [TS_WIDTH-1:0]       r_ts, r_evt_ts;
  logic [EVT_WIDTH-1:0]      r_evt_cnt, r_lost;
  logic [N_SOURCES:0]        r_evt_src;
  logic [PRESCALE_WIDTH-1:0] r_presc;
  logic [HOLDOFF_WIDTH-1:0]  r_hold;
  logic [BTO_W-1:0]          r_bto;
  logic                      r_seen;

  logic [N_SOURCES-1:0]      w_edge;
  logic [N_SOURCES:0]        w_q;
  logic                      w_qual, w_accept, w_presc_inc, w_dead, w_wb_done;
  state_t                    w_exit_state;

  assign w_edge = r_sync2 & ~r_hist;
  assign w_q    = {force_trigger_i, w_edge & source_mask_i};
  assign w_qual = |w_q;
  assign w_dead = (r_state == S_FIRE) || (r_state == S_WAIT_BUSY) ||
                  (r_state == S_HOLDOFF);

  // Busy cycle complete: busy was seen and has dropped, or busy never rose
  // and this is the last cycle of the timeout window.
  assign w_wb_done = !busy_i && (r_seen || (r_bto == BTO_LAST));

  // Where the dead time ends: straight back (no holdoff) or into HOLDOFF.
  assign w_exit_state = (holdoff_i != '0) ? S_HOLDOFF :
                        (enable_i ? S_ARMED : S_IDLE);

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_presc_inc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable_i) w_next = S_ARMED;
      end
      S_ARMED: begin
        // Disarm wins over a trigger arriving in the same cycle.
        if (!enable_i) begin
          w_next = S_IDLE;
        end else if (w_qual) begin
          if (r_presc == prescale_i) begin
            w_accept = 1'b1;
            w_next   = S_FIRE;
          end else begin
            w_presc_inc = 1'b1;
          end
        end
      end
      S_FIRE: begin
        w_next = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (w_wb_done) w_next = w_exit_state;
      end
      S_HOLDOFF: begin
        if (r_hold <= HOLDOFF_WIDTH'(1)) w_next = enable_i ? S_ARMED : S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_hist    <= '0;
      r_trigger <= 1'b0;
      r_armed   <= 1'b0;
      r_ts      <= '0;
      r_evt_ts  <= '0;
      r_evt_cnt <= '0;
      r_evt_src <= '0;
      r_lost    <= '0;
      r_presc   <= '0;
      r_hold    <= '0;
      r_bto     <= '0;
      r_seen    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_sync1   <= trigger_i;
      r_sync2   <= r_sync1;
      r_hist    <= r_sync2;
      r_trigger <= (w_next == S_FIRE);
      r_armed   <= (w_next == S_ARMED);

      r_ts <= clear_i ? '0 : r_ts + TS_WIDTH'(1);

      // Clear overrides the increment even on the accepting edge; the
      // start pulse and the captured timestamp/source are unaffected.
      if (clear_i)       r_evt_cnt <= '0;
      else if (w_accept) r_evt_cnt <= r_evt_cnt + EVT_WIDTH'(1);

      if (w_accept) begin
        r_evt_ts  <= r_ts;
        r_evt_src <= w_q;
      end

      if (clear_i)                              r_lost <= '0;
      else if (w_dead && w_qual && r_lost != '1) r_lost <= r_lost + EVT_WIDTH'(1);

      if (clear_i || w_accept) r_presc <= '0;
      else if (w_presc_inc)    r_presc <= r_presc + PRESCALE_WIDTH'(1);

      // Busy timeout window only advances while busy has not yet been seen.
      if (r_state != S_WAIT_BUSY) begin
        r_bto  <= '0;
        r_seen <= 1'b0;
      end else begin
        if (busy_i)               r_seen <= 1'b1;
        if (!r_seen && !busy_i)   r_bto  <= r_bto + BTO_W'(1);
      end

      if (r_state == S_WAIT_BUSY && w_next == S_HOLDOFF) r_hold <= holdoff_i;
      else if (r_state == S_HOLDOFF)                     r_hold <= r_hold - HOLDOFF_WIDTH'(1);
    end
  end

  assign trigger_o         = r_trigger;
  assign armed_o           = r_armed;
  assign state_o           = r_state;
  assign timestamp_o       = r_ts;
  assign event_count_o     = r_evt_cnt;
  assign event_timestamp_o = r_evt_ts;
  assign event_source_o    = r_evt_src;
  assign lost_count_o      = r_lost;

endmodule

// File: doc/daq_trigger_manager.md
# daq_trigger_manager

Parametrised trigger qualifier and sequencer sitting between the board trigger inputs and the DRS readout block's start input. Synchronises N asynchronous trigger sources, applies per-source masking, prescaling and a post-readout holdoff, and issues one start pulse per accepted event. Maintains a free-running timestamp and latches the event number, timestamp and firing sources per event. Counts triggers lost to dead time.

## Interface
- TS_WIDTH, 48, timestamp width
- EVT_WIDTH, 32, event and lost counter width
- N_SOURCES, 4, number of asynchronous trigger inputs
- PRESCALE_WIDTH, 16, prescale register width
- HOLDOFF_WIDTH, 16, holdoff register width
- BUSY_TIMEOUT, 15, max cycles to wait for busy_i to rise after a start pulse

- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- trigger_i  in  N_SOURCES  raw asynchronous triggers, active high
- source_mask_i  in  N_SOURCES  1 = source enabled
- force_trigger_i  in  1  synchronous software trigger, level sampled each cycle
- enable_i  in  1  arm enable
- clear_i  in  1  synchronous clear of counters and timestamp
- prescale_i  in  PRESCALE_WIDTH  accept 1 of every prescale_i+1 qualified triggers
- holdoff_i  in  HOLDOFF_WIDTH  dead cycles after busy_i falls
- busy_i  in  1  readout busy from DRS block
- trigger_o  out  1  one-cycle start pulse to DRS block
- armed_o  out  1  high in ARMED
- state_o  out  3  FSM state
- timestamp_o  out  TS_WIDTH  free-running counter
- event_count_o  out  EVT_WIDTH  accepted events
- event_timestamp_o  out  TS_WIDTH  timestamp at last accept
- event_source_o  out  N_SOURCES+1  sources firing at last accept; bit N_SOURCES = force
- lost_count_o  out  EVT_WIDTH  qualified triggers during dead time

## Operation
- Each trigger_i bit: 2-FF synchroniser plus history FF; edge = sync & ~history.
- Qualified vector q = {force_trigger_i, edge & source_mask_i}; qualified = |q.
- States: IDLE=0, ARMED=1, FIRE=2, WAIT_BUSY=3, HOLDOFF=4.
- IDLE: enable_i=1 -> ARMED. Qualified triggers ignored, not counted.
- ARMED: enable_i=0 -> IDLE (takes priority over a trigger in that cycle). Qualified: if prescale counter == prescale_i -> FIRE and counter := 0; else counter +1, stay ARMED. prescale_i=0 accepts every trigger.
- On entering FIRE: event_count_o +1 (wraps), event_timestamp_o := timestamp_o value before that edge's increment, event_source_o := q.
- FIRE: trigger_o=1 for exactly this cycle; -> WAIT_BUSY.
- WAIT_BUSY: waits for busy_i=1 then busy_i=0. If busy_i not seen high within BUSY_TIMEOUT cycles, exits as if busy fell. Exit: holdoff_i=0 -> ARMED (or IDLE if enable_i=0); else -> HOLDOFF with counter := holdoff_i.
- HOLDOFF: decrement each cycle; leaves after exactly holdoff_i cycles to ARMED, or IDLE if enable_i=0.
- Qualified triggers in FIRE, WAIT_BUSY or HOLDOFF: lost_count_o +1, saturating at all-ones. Prescale counter unchanged.
- timestamp_o increments every cycle, wraps.
- clear_i: timestamp_o, event_count_o, lost_count_o and prescale counter := 0; event_timestamp_o/event_source_o and FSM state unaffected. Clear coincident with FIRE entry: counter result is 0, pulse still issued.
- Reset: all outputs, counters and synchronisers 0; state IDLE.

## Timing
- Raw trigger: trigger_o high from the 3rd clock edge, counting the edge that first samples trigger_i high; 2-cycle minimum input pulse.
- force_trigger_i high before edge e in ARMED -> trigger_o high after e.
- trigger_o width exactly 1 cycle; min spacing between pulses = 3 + busy length + holdoff_i cycles.
- All outputs registered; state_o/armed_o update on the same edge as the transition.
- reset_n asserted mid-sequence: immediate IDLE, trigger_o=0, counters 0, no pulse after release until enable_i seen.

## Test plan
- Reset release, enable_i=1, mask=4'b0001, trigger_i[0] pulse 3 cycles -> trigger_o single pulse at 3rd edge, event_count_o=1, event_source_o=5'b00001.
- prescale_i=2, 9 force triggers spaced 20 cycles, busy_i tied low, holdoff_i=0 -> 3 pulses (triggers 3, 6, 9), lost_count_o=0.
- busy_i high 10 cycles after pulse, holdoff_i=5, force every cycle -> next pulse exactly 5 cycles after busy_i falls; lost_count_o increments by cycles spent dead.
- trigger_i[2] pulse with mask bit 2 = 0 -> no pulse; busy_i never rises -> WAIT_BUSY exits after 15 cycles.
- clear_i coincident with FIRE entry -> event_count_o=0, trigger_o still pulses, timestamp_o restarts at 0.
- reset_n low during HOLDOFF -> state_o=0, all counters 0, no pulse until re-armed.
